atp_change_dispenser: RTL

- Payout side of the Any Time Payment machine: the controller accepts notes; this block returns money.
- Takes an excess/refund amount from the ATP controller and dispenses it as notes (1000, 500, 100, 50, 20, 10, 5) through a note-dispenser mechanism handshake.
- Uses greedy largest-denomination selection against internal per-denomination inventory counters.
- Reports amount paid and undispensable residual back to the controller.

---
 rtl/atp_change_dispenser.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/atp_change_dispenser.sv
// atp_change_dispenser: payout side of the Any Time Payment machine.
// Dispenses a refund as notes (1000/500/100/50/20/10/5), always taking the
// largest denomination that still fits and is in stock, and reports the
// amount paid and the undispensable residual.
// Optional build macro: ATP_DISP_TIMEOUT_EN adds a note_ack watchdog with a
// sticky fault output. Without it, DISPENSE waits indefinitely for the ack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a request; inventory refills accepted here only
// SELECT   | pick lowest code with denom <= rem and a non-zero count
// DISPENSE | note_valid held with note_code until note_ack
// DONE     | one-cycle completion pulse with paid/residual/short
module atp_change_dispenser #(
  parameter int unsigned AW          = 10,
  parameter int unsigned CW          = 8,
  parameter int unsigned INIT_CNT    = 10,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req_valid,
  input  logic [AW-1:0] i_req_amount,
  output logic          o_req_ready,
  output logic          o_note_valid,
  output logic [2:0]    o_note_code,
  input  logic          i_note_ack,
  input  logic          i_refill_en,
  input  logic [2:0]    i_refill_sel,
  input  logic [CW-1:0] i_refill_cnt,
  output logic          o_done_valid,
  output logic [AW-1:0] o_done_paid,
  output logic [AW-1:0] o_done_residual,
  output logic          o_done_short,
  output logic [6:0]    o_cnt_empty,
  output logic          o_fault
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_DISPENSE, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_rem, w_rem_nxt;
  logic [AW-1:0] r_paid, w_paid_nxt;
  logic [CW-1:0] r_cnt [7];
  logic [CW-1:0] w_cnt_nxt [7];
  logic [2:0]    w_sel;
  logic          w_found;
  logic          r_req_ready;
  logic          r_note_valid;
  logic [2:0]    r_note_code, w_note_code_nxt;
  logic          r_done_valid;
  logic [AW-1:0] r_done_paid, w_done_paid_nxt;
  logic [AW-1:0] r_done_residual, w_done_residual_nxt;
  logic          r_done_short, w_done_short_nxt;
  logic [6:0]    r_cnt_empty;
  logic          w_fault_nxt;

`ifdef ATP_DISP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic          r_fault;
  assign o_fault = r_fault;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC == 0);
  assign w_fault_nxt  = 1'b0;
  assign o_fault      = 1'b0;
`endif

  assign o_req_ready     = r_req_ready;
  assign o_note_valid    = r_note_valid;
  assign o_note_code     = r_note_code;
  assign o_done_valid    = r_done_valid;
  assign o_done_paid     = r_done_paid;
  assign o_done_residual = r_done_residual;
  assign o_done_short    = r_done_short;
  assign o_cnt_empty     = r_cnt_empty;

  function automatic logic [AW-1:0] denom(input logic [2:0] code);
    case (code)
      3'd0:    denom = AW'(1000);
      3'd1:    denom = AW'(500);
      3'd2:    denom = AW'(100);
      3'd3:    denom = AW'(50);
      3'd4:    denom = AW'(20);
      3'd5:    denom = AW'(10);
      3'd6:    denom = AW'(5);
      default: denom = '0;
    endcase
  endfunction

  // Greedy pick: scan high code to low so the lowest eligible code wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (r_cnt[i] != '0 && denom(3'(i)) <= r_rem) begin
        w_found = 1'b1;
        w_sel   = 3'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and next datapath/output values.
  always_comb begin
    w_state_nxt         = r_state;
    w_rem_nxt           = r_rem;
    w_paid_nxt          = r_paid;
    w_cnt_nxt           = r_cnt;
    w_note_code_nxt     = r_note_code;
    w_done_paid_nxt     = r_done_paid;
    w_done_residual_nxt = r_done_residual;
    w_done_short_nxt    = r_done_short;
`ifdef ATP_DISP_TIMEOUT_EN
    w_fault_nxt         = r_fault;
    w_tmr_nxt           = r_tmr;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_refill_en) begin
          for (int i = 0; i < 7; i++) begin
            if (i_refill_sel == 3'(i)) w_cnt_nxt[i] = i_refill_cnt;
          end
        end
        if (i_req_valid && r_req_ready) begin
          w_state_nxt = S_SELECT;
          w_rem_nxt   = i_req_amount;
          w_paid_nxt  = '0;
        end
      end
      S_SELECT: begin
        if (w_found) begin
          w_state_nxt     = S_DISPENSE;
          w_note_code_nxt = w_sel;
`ifdef ATP_DISP_TIMEOUT_EN
          w_tmr_nxt       = TW'(TIMEOUT_CYC);
`endif
        end else begin
          w_state_nxt         = S_DONE;
          w_done_paid_nxt     = r_paid;
          w_done_residual_nxt = r_rem;
          w_done_short_nxt    = (r_rem >= AW'(5));
        end
      end
      S_DISPENSE: begin
        if (i_note_ack) begin
          w_rem_nxt   = r_rem - denom(r_note_code);
          w_paid_nxt  = r_paid + denom(r_note_code);
          for (int i = 0; i < 7; i++) begin
            if (r_note_code == 3'(i) && r_cnt[i] != '0) w_cnt_nxt[i] = r_cnt[i] - CW'(1);
          end
          w_state_nxt = S_SELECT;
        end
`ifdef ATP_DISP_TIMEOUT_EN
        else if (r_tmr == TW'(1)) begin
          // Mechanism stuck: abandon the note without charging inventory.
          w_fault_nxt         = 1'b1;
          w_state_nxt         = S_DONE;
          w_done_paid_nxt     = r_paid;
          w_done_residual_nxt = r_rem;
          w_done_short_nxt    = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - TW'(1);
        end
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, amount tracking and inventory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready     <= 1'b1;
      r_note_valid    <= 1'b0;
      r_note_code     <= 3'd0;
      r_done_valid    <= 1'b0;
      r_done_paid     <= '0;
      r_done_residual <= '0;
      r_done_short    <= 1'b0;
      r_rem           <= '0;
      r_paid          <= '0;
      for (int i = 0; i < 7; i++) begin
        r_cnt[i]       <= CW'(INIT_CNT);
        r_cnt_empty[i] <= (INIT_CNT == 0);
      end
`ifdef ATP_DISP_TIMEOUT_EN
      r_tmr           <= '0;
      r_fault         <= 1'b0;
`endif
    end else begin
      r_req_ready     <= (w_state_nxt == S_IDLE) && !w_fault_nxt;
      r_note_valid    <= (w_state_nxt == S_DISPENSE);
      r_note_code     <= w_note_code_nxt;
      r_done_valid    <= (w_state_nxt == S_DONE);
      r_done_paid     <= w_done_paid_nxt;
      r_done_residual <= w_done_residual_nxt;
      r_done_short    <= w_done_short_nxt;
      r_rem           <= w_rem_nxt;
      r_paid          <= w_paid_nxt;
      for (int i = 0; i < 7; i++) begin
        r_cnt[i]       <= w_cnt_nxt[i];
        r_cnt_empty[i] <= (w_cnt_nxt[i] == '0);
      end
`ifdef ATP_DISP_TIMEOUT_EN
      r_tmr           <= w_tmr_nxt;
      r_fault         <= w_fault_nxt;
`endif
    end
  end

endmodule
